// File: rtl/pong_pkg.sv
// Shared encodings for the pong game controller: states, datapath modes,
// winner codes and the USB HID keycodes the controller reacts to.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_TITLE = 3'b000,
      ST_PLAY  = 3'b001,
      ST_PAUSE = 3'b010,
      ST_WIN1  = 3'b011,
      ST_WIN2  = 3'b100
   } state_t;

   localparam logic [2:0] MODE_IDLE   = 3'b000;
   localparam logic [2:0] MODE_EASY   = 3'b001;
   localparam logic [2:0] MODE_MEDIUM = 3'b010;
   localparam logic [2:0] MODE_HARD   = 3'b011;
   localparam logic [2:0] MODE_AI     = 3'b100;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;

   localparam logic [7:0] KEY_1     = 8'h1E;
   localparam logic [7:0] KEY_2     = 8'h1F;
   localparam logic [7:0] KEY_3     = 8'h20;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_P     = 8'h13;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;

endpackage

// File: rtl/pong_key_edge.sv
// Presence of one keycode in the four-slot HID report and its rising edge.
// History resets to 1 so a key held through reset does not fire.
module pong_key_edge #(
   parameter logic [7:0] CODE = 8'h00
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [31:0] keycode,
   input  logic        valid,
   output logic        rise
);

   logic present;
   logic prev_q;

   always_comb begin
      present = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (keycode[i*8 +: 8] == CODE) present = 1'b1;
      end
      present = present & valid;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) prev_q <= 1'b1;
      else       prev_q <= present;
   end

   assign rise = present & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match controller: title/play/pause/win sequencing from keyboard edges
// and datapath scores, with registered mode, run enable and frame counter.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE   = 7,
   parameter int unsigned HOLD_FRAMES = 180
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [31:0] keycode,
   input  logic        valid,
   input  logic [8:0]  Score1,
   input  logic [8:0]  Score2,
   output logic [2:0]  Mode,
   output logic        run_en,
   output logic [2:0]  state_o,
   output logic [1:0]  winner,
   output logic [15:0] play_frames
);

   localparam int unsigned HW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;

   logic k1, k2, k3, ka, kp, kent, kesc;

   pong_key_edge #(.CODE(KEY_1)) u_key_1 (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(k1));
   pong_key_edge #(.CODE(KEY_2)) u_key_2 (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(k2));
   pong_key_edge #(.CODE(KEY_3)) u_key_3 (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(k3));
   pong_key_edge #(.CODE(KEY_A)) u_key_a (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(ka));
   pong_key_edge #(.CODE(KEY_P)) u_key_p (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(kp));
   pong_key_edge #(.CODE(KEY_ENTER)) u_key_enter (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(kent));
   pong_key_edge #(.CODE(KEY_ESC)) u_key_esc (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid), .rise(kesc));

   state_t          state_q, state_n;
   logic [2:0]      diff_q, diff_n;
   logic [1:0]      winner_q, winner_n;
   logic [HW-1:0]   hold_q, hold_n;
   logic [15:0]     frames_q, frames_n;
   logic [2:0]      mode_q, mode_n;
   logic            run_q, run_n;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_TITLE;
         diff_q   <= MODE_EASY;
         winner_q <= WINNER_NONE;
         hold_q   <= '0;
         frames_q <= '0;
         mode_q   <= MODE_IDLE;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         diff_q   <= diff_n;
         winner_q <= winner_n;
         hold_q   <= hold_n;
         frames_q <= frames_n;
         mode_q   <= mode_n;
         run_q    <= run_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      diff_n   = diff_q;
      winner_n = winner_q;
      hold_n   = hold_q;
      frames_n = frames_q;

      // A frame spent in PLAY counts even when it is the one that leaves PLAY.
      if (state_q == ST_PLAY && frames_q != '1) frames_n = frames_q + 16'd1;

      case (state_q)
         ST_TITLE: begin
            if (k1 | k2 | k3 | ka) begin
               if (k1)      diff_n = MODE_EASY;
               else if (k2) diff_n = MODE_MEDIUM;
               else if (k3) diff_n = MODE_HARD;
               else         diff_n = MODE_AI;
               frames_n = '0;
               winner_n = WINNER_NONE;
               state_n  = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (Score1 >= 9'(WIN_SCORE)) begin
               state_n  = ST_WIN1;
               winner_n = WINNER_P1;
               hold_n   = HW'(HOLD_FRAMES - 1);
            end else if (Score2 >= 9'(WIN_SCORE)) begin
               state_n  = ST_WIN2;
               winner_n = WINNER_P2;
               hold_n   = HW'(HOLD_FRAMES - 1);
            end else if (kesc) begin
               state_n = ST_TITLE;
            end else if (kp) begin
               state_n = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (kesc)    state_n = ST_TITLE;
            else if (kp) state_n = ST_PLAY;
         end
         ST_WIN1, ST_WIN2: begin
            if (hold_q == '0 || kent) state_n = ST_TITLE;
            else                      hold_n  = hold_q - HW'(1);
         end
         default: state_n = ST_TITLE;
      endcase

      mode_n = (state_n == ST_PLAY || state_n == ST_PAUSE) ? diff_n : MODE_IDLE;
      run_n  = (state_n == ST_PLAY);
   end

   assign Mode        = mode_q;
   assign run_en      = run_q;
   assign state_o     = state_q;
   assign winner      = winner_q;
   assign play_frames = frames_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: match start, pause, win hold and
// Enter exit, key qualifiers, priorities and reset with keys held.
module tb_pong_game_ctrl;

   logic        frame_clk;
   logic        Reset;
   logic [31:0] keycode;
   logic        valid;
   logic [8:0]  Score1, Score2;
   logic [2:0]  Mode;
   logic        run_en;
   logic [2:0]  state_o;
   logic [1:0]  winner;
   logic [15:0] play_frames;

   int errors = 0;
   int checks = 0;

   pong_game_ctrl #(.WIN_SCORE(7), .HOLD_FRAMES(180)) dut (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .valid(valid),
      .Score1(Score1), .Score2(Score2), .Mode(Mode), .run_en(run_en),
      .state_o(state_o), .winner(winner), .play_frames(play_frames));

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge frame_clk);
         #1;
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1; valid = 1'b0; keycode = '0; Score1 = '0; Score2 = '0;
      #2;
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL rst_state got=%b exp=000", state_o); end
      checks++; if (Mode !== 3'b000) begin errors++; $display("FAIL rst_mode got=%b exp=000", Mode); end
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL rst_run got=%b exp=0", run_en); end
      checks++; if (winner !== 2'b00) begin errors++; $display("FAIL rst_winner got=%b exp=00", winner); end
      checks++; if (play_frames !== 16'd0) begin errors++; $display("FAIL rst_frames got=%0d exp=0", play_frames); end
      #10;
      Reset = 1'b0;
      valid = 1'b1;
      tick(1);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL idle_title got=%b exp=000", state_o); end
   endtask

   task automatic test_start;
      keycode = 32'h0000_1F00;
      tick(1);
      checks++; if (state_o !== 3'b001) begin errors++; $display("FAIL start_state got=%b exp=001", state_o); end
      checks++; if (Mode !== 3'b010) begin errors++; $display("FAIL start_mode got=%b exp=010", Mode); end
      checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL start_run got=%b exp=1", run_en); end
      checks++; if (play_frames !== 16'd0) begin errors++; $display("FAIL start_frames got=%0d exp=0", play_frames); end
      keycode = '0;
      for (int f = 1; f <= 3; f++) begin
         tick(1);
         checks++; if (play_frames !== 16'(f)) begin errors++; $display("FAIL count_frames got=%0d exp=%0d", play_frames, f); end
      end
   endtask

   task automatic test_pause;
      keycode = 32'h0013_0000;
      tick(1);
      checks++; if (state_o !== 3'b010) begin errors++; $display("FAIL pause_state got=%b exp=010", state_o); end
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL pause_run got=%b exp=0", run_en); end
      checks++; if (Mode !== 3'b010) begin errors++; $display("FAIL pause_mode got=%b exp=010", Mode); end
      checks++; if (play_frames !== 16'd4) begin errors++; $display("FAIL pause_frames got=%0d exp=4", play_frames); end
      tick(4);
      checks++; if (state_o !== 3'b010) begin errors++; $display("FAIL pause_held got=%b exp=010", state_o); end
      checks++; if (play_frames !== 16'd4) begin errors++; $display("FAIL pause_frozen got=%0d exp=4", play_frames); end
      keycode = '0;
      tick(1);
      keycode = 32'h1300_0000;
      tick(1);
      checks++; if (state_o !== 3'b001) begin errors++; $display("FAIL resume_state got=%b exp=001", state_o); end
      checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL resume_run got=%b exp=1", run_en); end
      keycode = '0;
      tick(1);
      checks++; if (play_frames !== 16'd5) begin errors++; $display("FAIL resume_frames got=%0d exp=5", play_frames); end
   endtask

   task automatic test_win2_hold;
      Score2 = 9'd7;
      tick(1);
      checks++; if (state_o !== 3'b100) begin errors++; $display("FAIL win2_state got=%b exp=100", state_o); end
      checks++; if (winner !== 2'b10) begin errors++; $display("FAIL win2_winner got=%b exp=10", winner); end
      checks++; if (Mode !== 3'b000) begin errors++; $display("FAIL win2_mode got=%b exp=000", Mode); end
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL win2_run got=%b exp=0", run_en); end
      checks++; if (play_frames !== 16'd6) begin errors++; $display("FAIL win2_frames got=%0d exp=6", play_frames); end
      tick(179);
      checks++; if (state_o !== 3'b100) begin errors++; $display("FAIL hold_last got=%b exp=100", state_o); end
      tick(1);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL hold_expire got=%b exp=000", state_o); end
      checks++; if (winner !== 2'b10) begin errors++; $display("FAIL hold_winner got=%b exp=10", winner); end
      checks++; if (play_frames !== 16'd6) begin errors++; $display("FAIL hold_frames got=%0d exp=6", play_frames); end
      Score2 = '0;
   endtask

   task automatic test_win1_enter;
      keycode = 32'h0000_0020;
      tick(1);
      checks++; if (Mode !== 3'b011) begin errors++; $display("FAIL hard_mode got=%b exp=011", Mode); end
      checks++; if (winner !== 2'b00) begin errors++; $display("FAIL start_clr_winner got=%b exp=00", winner); end
      checks++; if (play_frames !== 16'd0) begin errors++; $display("FAIL start_clr_frames got=%0d exp=0", play_frames); end
      keycode = '0;
      tick(1);
      Score1 = 9'd7; keycode = 32'h0000_0028;
      tick(1);
      checks++; if (state_o !== 3'b011) begin errors++; $display("FAIL win1_state got=%b exp=011", state_o); end
      checks++; if (winner !== 2'b01) begin errors++; $display("FAIL win1_winner got=%b exp=01", winner); end
      tick(10);
      checks++; if (state_o !== 3'b011) begin errors++; $display("FAIL enter_held_win got=%b exp=011", state_o); end
      keycode = '0;
      tick(1);
      keycode = 32'h0028_0000;
      tick(1);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL enter_exit got=%b exp=000", state_o); end
      checks++; if (winner !== 2'b01) begin errors++; $display("FAIL enter_winner got=%b exp=01", winner); end
      tick(3);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL enter_title got=%b exp=000", state_o); end
      checks++; if (Mode !== 3'b000) begin errors++; $display("FAIL enter_title_mode got=%b exp=000", Mode); end
      keycode = '0; Score1 = '0;
      tick(1);
   endtask

   task automatic test_pause_esc_valid;
      keycode = 32'h0000_0004;
      tick(1);
      checks++; if (Mode !== 3'b100) begin errors++; $display("FAIL ai_mode got=%b exp=100", Mode); end
      keycode = '0; tick(1);
      keycode = 32'h0000_0013; tick(1);
      keycode = '0; tick(1);
      checks++; if (state_o !== 3'b010) begin errors++; $display("FAIL pe_paused got=%b exp=010", state_o); end
      keycode = 32'h0000_2913;
      tick(1);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL esc_over_p got=%b exp=000", state_o); end
      checks++; if (Mode !== 3'b000) begin errors++; $display("FAIL esc_mode got=%b exp=000", Mode); end
      keycode = '0; tick(1);
      valid = 1'b0; keycode = 32'h0000_001E;
      tick(2);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL invalid_key got=%b exp=000", state_o); end
      valid = 1'b1;
      tick(1);
      checks++; if (state_o !== 3'b001) begin errors++; $display("FAIL valid_edge got=%b exp=001", state_o); end
      checks++; if (Mode !== 3'b001) begin errors++; $display("FAIL valid_mode got=%b exp=001", Mode); end
      keycode = '0; Score1 = 9'd6;
      tick(1);
      checks++; if (state_o !== 3'b001) begin errors++; $display("FAIL below_win got=%b exp=001", state_o); end
      Score1 = 9'd7; Score2 = 9'd7;
      tick(1);
      checks++; if (state_o !== 3'b011) begin errors++; $display("FAIL p1_priority got=%b exp=011", state_o); end
      Score1 = '0; Score2 = '0; keycode = 32'h0000_0028;
      tick(1);
      keycode = '0;
      tick(1);
   endtask

   task automatic test_reset_held_key;
      keycode = 32'h2000_001E;
      tick(1);
      checks++; if (Mode !== 3'b001) begin errors++; $display("FAIL title_priority got=%b exp=001", Mode); end
      tick(3);
      #3 Reset = 1'b1;
      #1;
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL midrst_state got=%b exp=000", state_o); end
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL midrst_run got=%b exp=0", run_en); end
      checks++; if (play_frames !== 16'd0) begin errors++; $display("FAIL midrst_frames got=%0d exp=0", play_frames); end
      tick(2);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL inrst_state got=%b exp=000", state_o); end
      Reset = 1'b0;
      tick(2);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL held_after_rst got=%b exp=000", state_o); end
      keycode = '0;
      tick(1);
      checks++; if (state_o !== 3'b000) begin errors++; $display("FAIL released got=%b exp=000", state_o); end
      keycode = 32'h0000_001E;
      tick(1);
      checks++; if (state_o !== 3'b001) begin errors++; $display("FAIL repress got=%b exp=001", state_o); end
      checks++; if (Mode !== 3'b001) begin errors++; $display("FAIL repress_mode got=%b exp=001", Mode); end
      keycode = '0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_pause();
      test_win2_hold();
      test_win1_enter();
      test_pause_esc_valid();
      test_reset_held_key();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
